// File: rtl/bp_pkg.sv
// bp_pkg -- shared definitions for the branch predictor.
//
// Holds the 2-bit saturating counter encoding and the function that computes
// a counter's next value from a resolved branch outcome. Imported by the
// predictor top level and its cache.
package bp_pkg;

   localparam int CTR_WIDTH = 2;

   // Counter encoding; the MSB is the predicted direction.
   localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
   localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
   localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
   localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

   // Next counter value for a resolved branch.
   // A miss allocates a weak counter leaning toward the observed direction;
   // a hit steps one position toward it and saturates at either end.
   function automatic logic [1:0] ctr_next(input logic       hit,
                                           input logic [1:0] ctr,
                                           input logic       taken);
      if (!hit) begin
         return taken ? CTR_WT : CTR_WNT;
      end
      if (taken) begin
         return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bp_cache.sv
// bp_cache -- direct-mapped tagged store with two combinational read ports
// and one synchronous write port.
//
// The set index is taken from addr[IW+1:2] (word-aligned PCs), and the whole
// address is kept as the tag, so two addresses only ever hit on an exact
// match. Synchronous reset invalidates every line.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ra0 / rd0 / rhit0 read port 0: address, data, hit
//   ra1 / rd1 / rhit1 read port 1: address, data, hit
//   we / wa / wd      write enable, address, data (allocates or overwrites)
module bp_cache #(
   parameter int DWIDTH = 2,
   parameter int AWIDTH = 32,
   parameter int LINES  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] ra0,
   output logic [DWIDTH-1:0] rd0,
   output logic              rhit0,
   input  logic [AWIDTH-1:0] ra1,
   output logic [DWIDTH-1:0] rd1,
   output logic              rhit1,
   input  logic              we,
   input  logic [AWIDTH-1:0] wa,
   input  logic [DWIDTH-1:0] wd
);

   localparam int IW = $clog2(LINES);

   logic [LINES-1:0]  valid_q;
   logic [AWIDTH-1:0] tag_q  [LINES];
   logic [DWIDTH-1:0] data_q [LINES];

   logic [IW-1:0] ri0, ri1, wi;

   assign ri0 = ra0[2 +: IW];
   assign ri1 = ra1[2 +: IW];
   assign wi  = wa[2 +: IW];

   // Valid bits are the only state that needs clearing on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wi] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wi]  <= wa;
         data_q[wi] <= wd;
      end
   end

   assign rd0   = data_q[ri0];
   assign rhit0 = valid_q[ri0] && (tag_q[ri0] == ra0);
   assign rd1   = data_q[ri1];
   assign rhit1 = valid_q[ri1] && (tag_q[ri1] == ra1);

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor -- 2-bit saturating-counter branch direction predictor.
//
// The fetch stage asks for a prediction on the guess port (port 0 of the
// cache); the execute stage reports resolved branches on the check port
// (port 1). A resolved branch's new counter is held for one cycle in an
// update stage and written to the cache the following cycle. Both ports
// bypass from that update stage so a counter change is visible the very
// next cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pc_guess            fetch PC to predict
//   is_br_guess         pc_guess is a conditional branch
//   br_taken_guess      predicted direction (combinational)
//   pc_check            PC of resolved branch
//   is_br_check         check fields valid this cycle
//   br_taken_check      actual direction
//   stat_branches       resolved-branch count
//   stat_mispredicts    misprediction count
//
// Optional build macro BP_STATS_EN: when defined, the two statistics
// counters are implemented; otherwise the stat outputs are tied to zero.
//
// Handshake: there is no back-pressure. A check is accepted in every cycle
// where is_br_check=1 and reset=0; a guess is answered in the same cycle.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int PC_WIDTH = 32,
   parameter int LINES    = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] pc_guess,
   input  logic                is_br_guess,
   output logic                br_taken_guess,
   input  logic [PC_WIDTH-1:0] pc_check,
   input  logic                is_br_check,
   input  logic                br_taken_check,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
);

   // Cache read results.
   logic [CTR_WIDTH-1:0] c_rd0, c_rd1;
   logic                 c_hit0, c_hit1;
   logic                 cache_we;

   // Update stage: the counter value computed for last cycle's check.
   logic                 upd_valid;
   logic [PC_WIDTH-1:0]  upd_pc;
   logic [CTR_WIDTH-1:0] upd_ctr;

   // Guess-side view (cache or bypass).
   logic                 fwd_guess;
   logic                 guess_hit;
   logic [CTR_WIDTH-1:0] guess_ctr;

   // Check-side view (cache or bypass).
   logic                 fwd_check;
   logic                 chk_hit;
   logic [CTR_WIDTH-1:0] chk_ctr;
   logic [CTR_WIDTH-1:0] chk_next;

   bp_cache #(
      .DWIDTH (CTR_WIDTH),
      .AWIDTH (PC_WIDTH),
      .LINES  (LINES)
   ) u_cache (
      .clk   (clk),
      .reset (reset),
      .ra0   (pc_guess),
      .rd0   (c_rd0),
      .rhit0 (c_hit0),
      .ra1   (pc_check),
      .rd1   (c_rd1),
      .rhit1 (c_hit1),
      .we    (cache_we),
      .wa    (upd_pc),
      .wd    (upd_ctr)
   );

   // The pending update is newer than anything in the cache, so a PC match
   // against it wins over the cache contents.
   assign fwd_guess = upd_valid && (upd_pc == pc_guess);
   assign guess_hit = fwd_guess || c_hit0;
   assign guess_ctr = fwd_guess ? upd_ctr : c_rd0;

   assign br_taken_guess = is_br_guess && guess_hit && guess_ctr[1];

   assign fwd_check = upd_valid && (upd_pc == pc_check);
   assign chk_hit   = fwd_check || c_hit1;
   assign chk_ctr   = fwd_check ? upd_ctr : c_rd1;
   assign chk_next  = ctr_next(chk_hit, chk_ctr, br_taken_check);

   always_ff @(posedge clk) begin
      if (reset) begin
         upd_valid <= 1'b0;
      end else begin
         upd_valid <= is_br_check;
      end
   end

   always_ff @(posedge clk) begin
      upd_pc  <= pc_check;
      upd_ctr <= chk_next;
   end

   // A pending entry caught by reset is dropped rather than written.
   assign cache_we = upd_valid && !reset;

`ifdef BP_STATS_EN
   logic        chk_pred;
   logic [31:0] br_cnt;
   logic [31:0] mis_cnt;

   // The prediction that fetch would have seen: pre-update MSB, 0 on miss.
   assign chk_pred = chk_hit && chk_ctr[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else if (is_br_check) begin
         br_cnt <= br_cnt + 32'd1;
         if (chk_pred != br_taken_check) begin
            mis_cnt <= mis_cnt + 32'd1;
         end
      end
   end

   assign stat_branches    = br_cnt;
   assign stat_mispredicts = mis_cnt;
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor -- directed bench for branch_predictor.
//
// A direct-mapped table model (set = (pc>>2) mod LINES, exact-PC tag) is
// updated as soon as a check is accepted; because the design bypasses its
// update stage, that view matches the outputs on every cycle as long as a
// different PC of the same set is not touched in the cycle right after a
// check. The directed sequences respect that. Hand-computed literal guesses
// and statistics pin the model.
module tb_branch_predictor;

   localparam int PCW   = 32;
   localparam int LINES = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [PCW-1:0]  pc_guess;
   logic            is_br_guess;
   logic            br_taken_guess;
   logic [PCW-1:0]  pc_check;
   logic            is_br_check;
   logic            br_taken_check;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;

   int   n_vec  = 0;
   int   n_fail = 0;
   logic chk_on = 1'b0;

   // Reference model state.
   logic            m_valid [LINES];
   logic [PCW-1:0]  m_pc    [LINES];
   int              m_ctr   [LINES];
   logic [31:0]     exp_br  = '0;
   logic [31:0]     exp_mis = '0;

   branch_predictor #(
      .PC_WIDTH (PCW),
      .LINES    (LINES)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pc_guess         (pc_guess),
      .is_br_guess      (is_br_guess),
      .br_taken_guess   (br_taken_guess),
      .pc_check         (pc_check),
      .is_br_check      (is_br_check),
      .br_taken_check   (br_taken_check),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic int set_of(input logic [PCW-1:0] pc);
      return int'(pc >> 2) % LINES;
   endfunction

   function automatic logic m_hit(input logic [PCW-1:0] pc);
      return m_valid[set_of(pc)] && (m_pc[set_of(pc)] == pc);
   endfunction

   function automatic logic m_pred(input logic [PCW-1:0] pc);
      return m_hit(pc) && (m_ctr[set_of(pc)] >= 2);
   endfunction

   function automatic int m_next(input logic [PCW-1:0] pc, input logic tk);
      int c;
      if (!m_hit(pc)) return tk ? 2 : 1;
      c = m_ctr[set_of(pc)];
      if (tk) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   initial begin
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_pc[i]    = '0;
         m_ctr[i]   = 0;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
         exp_br  <= '0;
         exp_mis <= '0;
      end else if (is_br_check) begin
         m_valid[set_of(pc_check)] <= 1'b1;
         m_pc[set_of(pc_check)]    <= pc_check;
         m_ctr[set_of(pc_check)]   <= m_next(pc_check, br_taken_check);
         exp_br  <= exp_br + 32'd1;
         exp_mis <= exp_mis + ((m_pred(pc_check) != br_taken_check) ? 32'd1 : 32'd0);
      end
      chk_on <= 1'b1;
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         if (!reset) begin
            check("model_guess", {31'd0, br_taken_guess},
                  {31'd0, is_br_guess && m_pred(pc_guess)});
         end
`ifdef BP_STATS_EN
         check("model_branches", stat_branches, exp_br);
         check("model_mispredicts", stat_mispredicts, exp_mis);
`else
         check("stat_branches_tied", stat_branches, 32'd0);
         check("stat_mispredicts_tied", stat_mispredicts, 32'd0);
`endif
      end
   end

   // ---------------- drivers ----------------
   // One cycle: inputs held from just after a rising edge to the next one.
   // exp_g < 0 skips the literal guess check.
   task automatic cyc(input logic rst_i,
                      input logic [PCW-1:0] gpc, input logic gbr,
                      input logic [PCW-1:0] cpc, input logic cbr, input logic ctk,
                      input int exp_g, input string name);
      reset          = rst_i;
      pc_guess       = gpc;
      is_br_guess    = gbr;
      pc_check       = cpc;
      is_br_check    = cbr;
      br_taken_check = ctk;
      @(negedge clk);
      if (exp_g >= 0) check(name, {31'd0, br_taken_guess}, exp_g[31:0]);
      @(posedge clk);
      #1;
   endtask

   task automatic guess(input logic [PCW-1:0] pc, input int exp_g, input string name);
      cyc(1'b0, pc, 1'b1, '0, 1'b0, 1'b0, exp_g, name);
   endtask

   task automatic chk_guess(input logic [PCW-1:0] cpc, input logic tk,
                            input logic [PCW-1:0] gpc, input int exp_g, input string name);
      cyc(1'b0, gpc, 1'b1, cpc, 1'b1, tk, exp_g, name);
   endtask

   task automatic do_reset();
      cyc(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, -1, "reset");
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, -1, "idle");
   endtask

   task automatic check_stats(input string name, input logic [31:0] eb, input logic [31:0] em);
`ifdef BP_STATS_EN
      check({name, "_branches"}, stat_branches, eb);
      check({name, "_mispredicts"}, stat_mispredicts, em);
`else
      check({name, "_branches_off"}, stat_branches, 32'd0);
      check({name, "_mispredicts_off"}, stat_mispredicts, 32'd0);
      if (eb == 32'hFFFF_FFFF) $display("unexpected stats sentinel %0h", em);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, -1, "reset0");
      cyc(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, -1, "reset1");
      check_stats("after_reset", 32'd0, 32'd0);

      // Cold miss then allocation.
      guess('h100, 0, "cold_guess");
      chk_guess('h100, 1'b1, 'h100, 0, "cold_same_cycle");
      guess('h100, 1, "cold_bypass");
      guess('h100, 1, "cold_stored");
      cyc(1'b0, 'h100, 1'b0, '0, 1'b0, 1'b0, 0, "not_a_branch");
      guess('h104, 0, "other_pc_miss");
      guess('h10C, 0, "idle_gap0");

      // Saturation on 0x200.
      chk_guess('h200, 1'b1, 'h200, 0, "sat_t1");
      chk_guess('h200, 1'b1, 'h200, 1, "sat_t2");
      chk_guess('h200, 1'b1, 'h200, 1, "sat_t3");
      chk_guess('h200, 1'b1, 'h200, 1, "sat_t4");
      chk_guess('h200, 1'b0, 'h200, 1, "sat_n1");
      chk_guess('h200, 1'b0, 'h200, 1, "sat_n2_still_taken");
      chk_guess('h200, 1'b0, 'h200, 0, "sat_n3");
      guess('h200, 0, "sat_floor");
      guess('h10C, 0, "idle_gap1");

      // Bypass on back-to-back checks of 0x300; NT steps prove it reached 11.
      chk_guess('h300, 1'b1, 'h300, 0, "byp_n");
      chk_guess('h300, 1'b1, 'h300, 1, "byp_n1");
      chk_guess('h300, 1'b0, 'h300, 1, "byp_from_st");
      chk_guess('h300, 1'b0, 'h300, 1, "byp_wt");
      guess('h300, 0, "byp_wnt");
      guess('h10C, 0, "idle_gap2");

      // Reset while an update is pending; a check in the reset cycle is ignored.
      chk_guess('h400, 1'b1, 'h400, 0, "rst_chk");
      reset = 1'b1; pc_guess = 'h400; is_br_guess = 1'b1;
      pc_check = 'h600; is_br_check = 1'b1; br_taken_check = 1'b1;
      @(negedge clk);
      check("rst_we_blocked", {31'd0, dut.cache_we}, 32'd0);
      @(posedge clk);
      #1;
      guess('h400, 0, "rst_discarded");
      guess('h600, 0, "rst_chk_ignored");
      guess('h200, 0, "rst_cleared_old");
      check_stats("rst_stats", 32'd0, 32'd0);

      // Statistics: T,N,T,T on 0x500 -> 4 branches, 3 mispredicts.
      do_reset();
      chk_guess('h500, 1'b1, 'h500, 0, "st_t1");
      chk_guess('h500, 1'b0, 'h500, 1, "st_n");
      chk_guess('h500, 1'b1, 'h500, 0, "st_t2");
      chk_guess('h500, 1'b1, 'h500, 1, "st_t3");
      guess('h500, 1, "st_final");
      check_stats("stats", 32'd4, 32'd3);

      // Aliasing: 0x0 and 0x0+4*LINES share one set.
      do_reset();
      chk_guess('h0, 1'b1, 'h0, 0, "al_a_alloc");
      guess(4 * LINES, 0, "al_b_miss");
      guess('h0, 1, "al_a_hit");
      chk_guess(4 * LINES, 1'b0, 4 * LINES, 0, "al_b_alloc");
      guess(4 * LINES, 0, "al_b_wnt");
      guess('h0, 0, "al_a_evicted");
      chk_guess(4 * LINES, 1'b1, 4 * LINES, 0, "al_b_t1");
      chk_guess(4 * LINES, 1'b1, 4 * LINES, 1, "al_b_t2");
      guess(4 * LINES, 1, "al_b_st");
      guess('h0, 0, "al_a_still_miss");
      chk_guess('h0, 1'b1, 'h0, 0, "al_a_realloc");
      guess('h0, 1, "al_a_back");
      guess(4 * LINES, 0, "al_b_evicted");

      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, -1, "drain");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
